ldm_stm_sequencer: RTL and testbench

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

---
 rtl/ldm_stm_sequencer_pkg.sv | 21 ++
 rtl/ldm_stm_sequencer_lowest_set_bit.sv | 17 +
 rtl/ldm_stm_sequencer.sv | 159 +++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] R15        = 4'd15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Combinational priority picker: index of the lowest set bit of a 16-bit list.
module lowest_set_bit (
  input  logic [15:0] list,
  output logic [3:0]  index,
  output logic        valid
);

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) index = 4'(i);
    end
    valid = |list;
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer: walks a latched register list one
// register per cycle, then optionally writes the updated base back to Rn.
// Handshake: Start is a one-cycle request honoured only while Busy=0; Done
// pulses for one cycle when the operation (including any writeback) is over.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        IsLoad,
  input  logic        Up,
  input  logic        PreIndex,
  input  logic        Writeback,
  input  logic [15:0] RegList,
  input  logic [3:0]  Rn,
  input  logic [31:0] BaseAddr,
  input  logic [31:0] ReadData,
  input  logic [31:0] RD1,
  output logic [3:0]  A1,
  output logic [3:0]  A3,
  output logic [31:0] WD3,
  output logic        WE3,
  output logic [31:0] MemAddr,
  output logic        MemWrite,
  output logic [31:0] WriteData,
  output logic        PCLoad,
  output logic [31:0] PCData,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] WORD = 32'(WORD_BYTES);

  state_t      state, state_next;
  logic [15:0] list_q;
  logic        is_load_q, up_q, wb_q, rn_in_list_q;
  logic [3:0]  rn_q;
  logic [31:0] base_q, addr_q;
  logic [4:0]  count_q;

  logic [3:0]  cur_idx;
  logic        cur_valid;
  logic        accept, last_xfer;
  logic [4:0]  start_count;
  logic [31:0] start_span, start_addr, wb_span, wb_value;

  lowest_set_bit u_lsb (
    .list  (list_q),
    .index (cur_idx),
    .valid (cur_valid)
  );

  assign accept      = (state == ST_IDLE) && Start;
  assign last_xfer   = ((list_q & (list_q - 16'd1)) == 16'd0);
  assign start_count = popcount16(RegList);
  assign start_span  = 32'(start_count) * WORD;
  assign wb_span     = 32'(count_q) * WORD;
  assign wb_value    = up_q ? (base_q + wb_span) : (base_q - wb_span);

  // Lowest transfer address for each U/P addressing mode.
  always_comb begin
    start_addr = BaseAddr;
    unique case ({Up, PreIndex})
      2'b10: start_addr = BaseAddr;
      2'b11: start_addr = BaseAddr + WORD;
      2'b00: start_addr = BaseAddr - start_span + WORD;
      2'b01: start_addr = BaseAddr - start_span;
      default: start_addr = BaseAddr;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (Start) state_next = (RegList != 16'd0) ? ST_XFER : ST_DONE;
      ST_XFER: if (last_xfer) state_next = wb_q ? ST_WB : ST_DONE;
      ST_WB:   state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      list_q        <= '0;
      is_load_q     <= 1'b0;
      up_q          <= 1'b0;
      wb_q          <= 1'b0;
      rn_in_list_q  <= 1'b0;
      rn_q          <= '0;
      base_q        <= '0;
      addr_q        <= '0;
      count_q       <= '0;
    end else if (accept) begin
      list_q        <= RegList;
      is_load_q     <= IsLoad;
      up_q          <= Up;
      wb_q          <= Writeback;
      rn_in_list_q  <= RegList[Rn];
      rn_q          <= Rn;
      base_q        <= BaseAddr;
      addr_q        <= start_addr;
      count_q       <= start_count;
    end else if (state == ST_XFER && cur_valid) begin
      list_q <= list_q & ~(16'd1 << cur_idx);
      addr_q <= addr_q + WORD;
    end
  end

  always_comb begin
    A1        = '0;
    A3        = '0;
    WD3       = '0;
    WE3       = 1'b0;
    MemAddr   = '0;
    MemWrite  = 1'b0;
    WriteData = '0;
    PCLoad    = 1'b0;
    PCData    = '0;
    Busy      = (state != ST_IDLE);
    Done      = 1'b0;
    dbg_state = state;
    unique case (state)
      ST_XFER: begin
        MemAddr = addr_q;
        if (is_load_q) begin
          if (cur_idx == R15) begin
            PCLoad = 1'b1;
            PCData = {ReadData[31:2], 2'b00};
          end else begin
            A3  = cur_idx;
            WD3 = ReadData;
            WE3 = 1'b1;
          end
        end else begin
          A1        = cur_idx;
          WriteData = RD1;
          MemWrite  = 1'b1;
        end
      end
      ST_WB: begin
        // A loaded Rn keeps its loaded value; the base update is dropped.
        A3  = rn_q;
        WD3 = wb_value;
        WE3 = !(is_load_q && rn_in_list_q);
      end
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a transfer-level model pushes the
// expected strobe events; a negedge monitor pops and compares them.
module tb_ldm_stm_sequencer;

  localparam int W = 82;
  localparam logic [3:0] K_WE3  = 4'b0001;
  localparam logic [3:0] K_MEM  = 4'b0010;
  localparam logic [3:0] K_PC   = 4'b0100;
  localparam logic [3:0] K_DONE = 4'b1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0;
  logic        is_load = 1'b0, up = 1'b0, pre_index = 1'b0, writeback = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  rn = '0;
  logic [31:0] base_addr = '0;
  logic [31:0] read_data, rd1;
  logic [3:0]  a1, a3;
  logic [31:0] wd3, mem_addr, write_data, pc_data;
  logic        we3, mem_write, pc_load, busy, done;
  logic [1:0]  dbg_state;

  logic [31:0] cyc = '0, start_cyc = '0;
  logic        rd_override = 1'b0;
  logic [31:0] rd_override_val = '0;
  int          vectors = 0, miscompares = 0;
  logic [W-1:0] exp_q[$];

  ldm_stm_sequencer dut (
    .CLK(clk), .Reset(reset), .Start(start), .IsLoad(is_load), .Up(up),
    .PreIndex(pre_index), .Writeback(writeback), .RegList(reg_list), .Rn(rn),
    .BaseAddr(base_addr), .ReadData(read_data), .RD1(rd1), .A1(a1), .A3(a3),
    .WD3(wd3), .WE3(we3), .MemAddr(mem_addr), .MemWrite(mem_write),
    .WriteData(write_data), .PCLoad(pc_load), .PCData(pc_data), .Busy(busy),
    .Done(done), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] reg_word(input logic [3:0] i);
    return {16'hC0DE, i, i, i, i};
  endfunction

  assign read_data = rd_override ? rd_override_val : mem_word(mem_addr);
  assign rd1       = reg_word(a1);

  function automatic logic [W-1:0] rec(input logic [3:0] kind, input logic [3:0] idx,
                                       input logic [31:0] addr, input logic [31:0] data,
                                       input int rel);
    return {1'b1, kind, idx, addr, data, 8'(rel)};
  endfunction

  // Reference model: one event per transferred register, optional base update, Done.
  task automatic model_push(input logic l, input logic u, input logic p, input logic w,
                            input logic [15:0] lst, input logic [3:0] r, input logic [31:0] b);
    int n, rel;
    logic [31:0] a, d;
    n = 0;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    if (u) a = p ? b + 32'd4 : b;
    else   a = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
    rel = 1;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        d = rd_override ? rd_override_val : mem_word(a);
        if (!l)         exp_q.push_back(rec(K_MEM, 4'(i), a, reg_word(4'(i)), rel));
        else if (i == 15) exp_q.push_back(rec(K_PC, 4'd0, a, d & 32'hFFFF_FFFC, rel));
        else            exp_q.push_back(rec(K_WE3, 4'(i), a, d, rel));
        a = a + 32'd4;
        rel++;
      end
    end
    if (n > 0 && w) begin
      if (!(l && lst[r]))
        exp_q.push_back(rec(K_WE3, r, 32'd0, u ? b + 32'(4 * n) : b - 32'(4 * n), rel));
      rel++;
    end
    exp_q.push_back(rec(K_DONE, 4'd0, 32'd0, 32'd0, rel));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [3:0]   kind, idx;
    logic [31:0]  data;
    logic [W-1:0] obs, expv;
    kind = {done, pc_load, mem_write, we3};
    if (kind != 4'd0) begin
      idx  = we3 ? a3 : (mem_write ? a1 : 4'd0);
      data = we3 ? wd3 : mem_write ? write_data : pc_load ? pc_data : 32'd0;
      obs  = {busy, kind, idx, mem_addr, data, 8'(cyc - start_cyc)};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe got=%h expected=none", obs);
      end else begin
        expv = exp_q.pop_front();
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL strobe got=%h expected=%h", obs, expv);
        end
      end
    end else if (busy !== 1'b1) begin
      vectors++;
      if ({busy, a1, a3, wd3, mem_addr, write_data, pc_data} !== '0) begin
        miscompares++;
        $display("FAIL idle_outputs got a1=%h a3=%h wd3=%h addr=%h wdata=%h pc=%h busy=%b expected all 0",
                 a1, a3, wd3, mem_addr, write_data, pc_data, busy);
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic l, input logic u, input logic p, input logic w,
                       input logic [15:0] lst, input logic [3:0] r, input logic [31:0] b);
    @(posedge clk); #1;
    model_push(l, u, p, w, lst, r, b);
    is_load = l; up = u; pre_index = p; writeback = w;
    reg_list = lst; rn = r; base_addr = b;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic scramble();
    start     = 1'($urandom_range(0, 1));
    is_load   = 1'($urandom_range(0, 1));
    up        = 1'($urandom_range(0, 1));
    pre_index = 1'($urandom_range(0, 1));
    writeback = 1'($urandom_range(0, 1));
    reg_list  = 16'($urandom);
    rn        = 4'($urandom_range(0, 15));
    base_addr = $urandom;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      scramble();
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout got=no Done expected=Done within 40 cycles");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic l, input logic u, input logic p, input logic w,
                        input logic [15:0] lst, input logic [3:0] r, input logic [31:0] b);
    issue(l, u, p, w, lst, r, b);
    wait_done();
  endtask

  initial begin
    logic [15:0] lst;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_op(1, 1, 0, 1, 16'h000E, 4'd0, 32'h0000_0100);  // LDMIA with writeback
    run_op(0, 0, 1, 0, 16'h8001, 4'd0, 32'h0000_0200);  // STMDB incl. R15
    run_op(1, 1, 0, 1, 16'h0000, 4'd3, 32'h0000_0500);  // empty list
    run_op(1, 1, 0, 1, 16'h0004, 4'd2, 32'h0000_0700);  // Rn in list, WB suppressed
    run_op(0, 0, 0, 1, 16'h00A0, 4'd9, 32'h0000_0010);  // STMDA with writeback
    rd_override = 1'b1;
    rd_override_val = 32'h0000_0043;
    run_op(1, 1, 1, 0, 16'h8003, 4'd4, 32'h0000_0300);  // LDMIB incl. R15
    rd_override = 1'b0;

    // Reset during the second transfer cycle of a 4-register load.
    issue(1, 1, 0, 0, 16'h00F0, 4'd1, 32'h0000_0400);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_op got busy=%b pending=%0d expected busy=0 pending=0", busy, exp_q.size());
    end
    run_op(1, 0, 1, 1, 16'h0C01, 4'd5, 32'h0000_1000);

    // Reset wins over a simultaneous Start.
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; reg_list = 16'h0003;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_priority got busy=%b expected busy=0", busy);
    end
    repeat (2) @(posedge clk);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0:       lst = 16'h0000;
        1:       lst = 16'd1 << $urandom_range(0, 15);
        default: lst = 16'($urandom);
      endcase
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), lst, 4'($urandom_range(0, 15)), $urandom);
    end

    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected got=%0d pending expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
